// File: rtl/mem_handle_server_pkg.sv
// Shared types for the per-handle memory responder: sizes, handle struct, server states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package mem_pkg;

  localparam int ADDR_SIZE = 23;
  localparam int DATA_SIZE = 32;

  // One worker-side handle. The server reads only the initiator-driven
  // fields; avail/done are regenerated by the server on its own outputs.
  typedef struct packed {
    logic [ADDR_SIZE-1:0] region_begin;
    logic [ADDR_SIZE-1:0] region_end;
    logic [ADDR_SIZE-1:0] ptr;
    logic                 w_en;
    logic                 r_en;
    logic                 write_through;
    logic                 read_through;
    logic [DATA_SIZE-1:0] data;
    logic                 avail;
    logic                 done;
  } mem_handle_t;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RESP
  } mem_srv_state_t;

  // Half-open region [rb, re); an empty or inverted region admits nothing.
  function automatic logic in_region(input logic [ADDR_SIZE-1:0] ptr,
                                     input logic [ADDR_SIZE-1:0] rb,
                                     input logic [ADDR_SIZE-1:0] re);
    return (ptr >= rb) && (ptr < re);
  endfunction

endpackage

// File: rtl/mem_handle_server_if.sv
// Bundle of the handle-side and memory-side signals of one mem_handle_server.
// Latency: n/a (wires only).
// Backpressure: avail gates new handle requests; mem_req is held until mem_gnt.
// slave  : the server (consumes h and the memory responses, drives the rest)
// master : the environment (initiator plus memory arbiter)
interface mem_handle_server_if;

  mem_pkg::mem_handle_t                h;
  logic                                avail;
  logic                                done;
  logic                                err;
  logic [mem_pkg::DATA_SIZE-1:0]       rdata;
  logic                                mem_req;
  logic                                mem_we;
  logic [mem_pkg::ADDR_SIZE-1:0]       mem_addr;
  logic [mem_pkg::DATA_SIZE-1:0]       mem_wdata;
  logic                                mem_gnt;
  logic                                mem_rvalid;
  logic [mem_pkg::DATA_SIZE-1:0]       mem_rdata;

  modport slave (
    input  h, mem_gnt, mem_rvalid, mem_rdata,
    output avail, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output h, mem_gnt, mem_rvalid, mem_rdata,
    input  avail, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_handle_server_buf.sv
// One-word write-back buffer entry with hit compare and dirty tracking.
// Latency: hit is combinational; fill/update/clean take effect on the next edge.
// Backpressure: none; the owner sequences all writes.
// Ports: cmp_addr/hit compare; fill_* loads a new entry (clean or dirty);
//        upd_* overwrites data of the current entry and marks it clean;
//        clean_en clears dirty after a flush is accepted.
module mem_word_buf
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [ADDR_SIZE-1:0] cmp_addr,
  output logic                 hit,
  output logic                 bdirty,
  output logic [ADDR_SIZE-1:0] baddr,
  output logic [DATA_SIZE-1:0] bdata,
  input  logic                 fill_en,
  input  logic                 fill_dirty,
  input  logic [ADDR_SIZE-1:0] fill_addr,
  input  logic [DATA_SIZE-1:0] fill_data,
  input  logic                 upd_en,
  input  logic [DATA_SIZE-1:0] upd_data,
  input  logic                 clean_en
);

  logic bvalid;

  assign hit = bvalid && (baddr == cmp_addr);

  // fill wins over clean: a write-back write completing in the same cycle as
  // the flush grant must leave the new entry dirty.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bvalid <= 1'b0;
      bdirty <= 1'b0;
      baddr  <= '0;
      bdata  <= '0;
    end else if (fill_en) begin
      bvalid <= 1'b1;
      bdirty <= fill_dirty;
      baddr  <= fill_addr;
      bdata  <= fill_data;
    end else if (upd_en) begin
      bdata  <= upd_data;
      bdirty <= 1'b0;
    end else if (clean_en) begin
      bdirty <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_handle_server.sv
// Per-handle memory responder: region check, one-word write-back buffer, memory port.
// Latency: hit/reject/buffered write done at N+1; memory accesses add grant/rvalid waits.
// Backpressure: avail low while busy; mem_req/we/addr/wdata held stable until mem_gnt.
// Ports: clk, rst_l (async, active-low); bus (slave modport) carries the handle
//        request h, avail/done/err/rdata and the mem_* request/response port.
module mem_handle_server
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_l,
  mem_handle_server_if.slave  bus
);

  mem_srv_state_t       state_q, state_n;
  logic                 ready_q;
  logic [ADDR_SIZE-1:0] ptr_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 we_q, wt_q, rt_q, err_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic                 mem_req_q, mem_we_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;

  logic                 avail, accept, reject;
  logic [ADDR_SIZE-1:0] cur_ptr;
  logic [DATA_SIZE-1:0] cur_data;

  logic                 hit, bdirty;
  logic [ADDR_SIZE-1:0] baddr;
  logic [DATA_SIZE-1:0] bdata;
  logic                 fill_en, fill_dirty, upd_en, clean_en;
  logic [ADDR_SIZE-1:0] fill_addr;
  logic [DATA_SIZE-1:0] fill_data;
  logic                 rd_buf, rd_mem;

  logic unused_h;
  assign unused_h = bus.h.avail ^ bus.h.done;

  // ready_q keeps avail low for the first edge after reset release.
  assign avail   = ready_q && (state_q == IDLE);
  assign accept  = avail && (bus.h.r_en || bus.h.w_en);
  assign reject  = (bus.h.r_en && bus.h.w_en) ||
                   !in_region(bus.h.ptr, bus.h.region_begin, bus.h.region_end);

  // In IDLE decisions are made on the live request; afterwards on the latched copy.
  assign cur_ptr  = (state_q == IDLE) ? bus.h.ptr  : ptr_q;
  assign cur_data = (state_q == IDLE) ? bus.h.data : data_q;

  mem_word_buf u_buf (
    .clk        (clk),
    .rst_l      (rst_l),
    .cmp_addr   (cur_ptr),
    .hit        (hit),
    .bdirty     (bdirty),
    .baddr      (baddr),
    .bdata      (bdata),
    .fill_en    (fill_en),
    .fill_dirty (fill_dirty),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .upd_en     (upd_en),
    .upd_data   (data_q),
    .clean_en   (clean_en)
  );

  always_comb begin
    state_n    = state_q;
    fill_en    = 1'b0;
    fill_dirty = 1'b0;
    fill_addr  = cur_ptr;
    fill_data  = cur_data;
    upd_en     = 1'b0;
    clean_en   = 1'b0;
    rd_buf     = 1'b0;
    rd_mem     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            state_n = RESP;
          end else if (bus.h.r_en) begin
            if (!bus.h.read_through) begin
              if (hit) begin
                state_n = RESP;
                rd_buf  = 1'b1;
              end else begin
                state_n = bdirty ? FLUSH : RD_REQ;
              end
            end else begin
              // A dirty hit must reach memory before a read that bypasses the buffer.
              state_n = (hit && bdirty) ? FLUSH : RD_REQ;
            end
          end else if (!bus.h.write_through) begin
            if (bdirty && !hit) begin
              state_n = FLUSH;
            end else begin
              fill_en    = 1'b1;
              fill_dirty = 1'b1;
              state_n    = RESP;
            end
          end else begin
            state_n = WR_REQ;
          end
        end
      end
      FLUSH: begin
        if (bus.mem_gnt) begin
          clean_en = 1'b1;
          if (we_q) begin
            // Only write-back writes flush on the write path; complete into the buffer.
            fill_en    = 1'b1;
            fill_dirty = 1'b1;
            state_n    = RESP;
          end else begin
            state_n = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bus.mem_gnt) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          rd_mem  = 1'b1;
          state_n = RESP;
          if (!rt_q) begin
            fill_en   = 1'b1;
            fill_data = bus.mem_rdata;
          end
        end
      end
      WR_REQ: begin
        if (bus.mem_gnt) begin
          state_n = RESP;
          upd_en  = hit;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      ptr_q       <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      wt_q        <= 1'b0;
      rt_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_n;
      ready_q <= 1'b1;
      if (accept) begin
        ptr_q  <= bus.h.ptr;
        data_q <= bus.h.data;
        we_q   <= bus.h.w_en;
        wt_q   <= bus.h.write_through;
        rt_q   <= bus.h.read_through;
        err_q  <= reject;
      end
      if (rd_buf) begin
        rdata_q <= bdata;
      end else if (rd_mem) begin
        rdata_q <= bus.mem_rdata;
      end
      // Memory port registers load only on entry to a request state, so the
      // request stays frozen until the grant moves the FSM on.
      if (state_n != state_q) begin
        case (state_n)
          FLUSH: begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= baddr;
            mem_wdata_q <= bdata;
          end
          RD_REQ: begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= cur_ptr;
          end
          WR_REQ: begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cur_ptr;
            mem_wdata_q <= cur_data;
          end
          default: begin
            mem_req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.avail     = avail;
  assign bus.done      = (state_q == RESP);
  assign bus.err       = (state_q == RESP) && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_handle_server.sv
// Randomized plus directed bench for mem_handle_server against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: bench memory grants after a programmable or random delay.
module tb_mem_handle_server;
  import mem_pkg::*;

  typedef struct {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] wdata;
    bit                   stable;
    int                   req_cycles;
    int                   first_cyc;
    int                   gnt_cyc;
  } op_t;

  logic clk;
  logic rst_l;
  int   cyc;
  int   n_checks;
  int   n_fail;

  mem_handle_server_if bus();

  mem_handle_server dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- backing memory (bench side) ----------------
  logic [DATA_SIZE-1:0] resp_mem  [int];
  logic [DATA_SIZE-1:0] model_mem [int];
  op_t obs_ops[$];
  op_t exp_ops[$];
  int  gnt_wait_cfg;
  int  rv_wait_cfg;

  function automatic logic [DATA_SIZE-1:0] dflt(input logic [ADDR_SIZE-1:0] a);
    return 32'h5A00_0000 ^ {9'd0, a};
  endfunction

  initial begin
    bit                   pend;
    op_t                  cap;
    int                   wait_cnt;
    int                   rv_cnt;
    logic [DATA_SIZE-1:0] rv_data;
    pend = 0;
    rv_cnt = 0;
    wait_cnt = 0;
    rv_data = '0;
    cap = '{we: 1'b0, addr: '0, wdata: '0, stable: 1'b1, req_cycles: 0, first_cyc: 0, gnt_cyc: 0};
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!rst_l) pend = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rv_data;
        end
      end
      if (!pend && rst_l && bus.mem_req === 1'b1) begin
        pend = 1;
        cap.we = bus.mem_we;
        cap.addr = bus.mem_addr;
        cap.wdata = bus.mem_wdata;
        cap.stable = 1;
        cap.req_cycles = 0;
        cap.first_cyc = cyc;
        wait_cnt = (gnt_wait_cfg >= 0) ? gnt_wait_cfg : int'($urandom_range(0, 3));
      end
      if (pend) begin
        if (bus.mem_req !== 1'b1 || bus.mem_we !== cap.we ||
            bus.mem_addr !== cap.addr || bus.mem_wdata !== cap.wdata) cap.stable = 0;
        cap.req_cycles++;
        if (wait_cnt == 0) begin
          bus.mem_gnt = 1'b1;
          pend = 0;
          cap.gnt_cyc = cyc;
          obs_ops.push_back(cap);
          if (cap.we) begin
            resp_mem[int'(cap.addr)] = cap.wdata;
          end else begin
            rv_data = resp_mem.exists(int'(cap.addr)) ? resp_mem[int'(cap.addr)] : dflt(cap.addr);
            rv_cnt  = (rv_wait_cfg >= 0) ? rv_wait_cfg : int'($urandom_range(1, 3));
          end
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit                   m_valid, m_dirty;
  logic [ADDR_SIZE-1:0] m_addr;
  logic [DATA_SIZE-1:0] m_data;

  function automatic logic [DATA_SIZE-1:0] model_rd(input logic [ADDR_SIZE-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : dflt(a);
  endfunction

  task automatic exp_op(input logic we, input logic [ADDR_SIZE-1:0] a, input logic [DATA_SIZE-1:0] d);
    op_t o;
    o = '{we: we, addr: a, wdata: d, stable: 1'b1, req_cycles: 0, first_cyc: 0, gnt_cyc: 0};
    exp_ops.push_back(o);
    if (we) model_mem[int'(a)] = d;
  endtask

  task automatic model_flush();
    exp_op(1'b1, m_addr, m_data);
    m_dirty = 0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [ADDR_SIZE-1:0] ptr,
                            input logic [DATA_SIZE-1:0] d, input logic wt, input logic rt,
                            input logic [ADDR_SIZE-1:0] rb, input logic [ADDR_SIZE-1:0] re,
                            output logic e_err, output logic [DATA_SIZE-1:0] e_rdata);
    bit hit;
    exp_ops.delete();
    e_rdata = '0;
    e_err = (r && w) || (ptr < rb) || (ptr >= re);
    if (e_err) return;
    hit = m_valid && (m_addr == ptr);
    if (r) begin
      if (!rt && hit) begin
        e_rdata = m_data;
      end else begin
        if ((!rt && m_dirty) || (rt && hit && m_dirty)) model_flush();
        e_rdata = model_rd(ptr);
        exp_op(1'b0, ptr, '0);
        if (!rt) begin
          m_valid = 1; m_dirty = 0; m_addr = ptr; m_data = e_rdata;
        end
      end
    end else if (!wt) begin
      if (m_dirty && !hit) model_flush();
      m_valid = 1; m_dirty = 1; m_addr = ptr; m_data = d;
    end else begin
      exp_op(1'b1, ptr, d);
      if (hit) begin
        m_data = d; m_dirty = 0;
      end
    end
  endtask

  // ---------------- request driver ----------------
  int last_acc, last_done;

  task automatic wait_avail();
    int t;
    t = 0;
    while (bus.avail !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
  endtask

  task automatic do_req(input logic r, input logic w, input logic [ADDR_SIZE-1:0] ptr,
                        input logic [DATA_SIZE-1:0] d, input logic wt, input logic rt,
                        input logic [ADDR_SIZE-1:0] rb, input logic [ADDR_SIZE-1:0] re);
    logic                 e_err;
    logic [DATA_SIZE-1:0] e_rdata;
    int                   t, n;
    wait_avail();
    check_eq("avail_before_req", bus.avail, 1'b1);
    model_step(r, w, ptr, d, wt, rt, rb, re, e_err, e_rdata);
    obs_ops.delete();
    bus.h.r_en = r;  bus.h.w_en = w;  bus.h.ptr = ptr;  bus.h.data = d;
    bus.h.write_through = wt;  bus.h.read_through = rt;
    bus.h.region_begin = rb;  bus.h.region_end = re;
    last_acc = cyc;
    @(posedge clk); #1;
    bus.h.r_en = 1'b0;  bus.h.w_en = 1'b0;
    t = 0;
    while (bus.done !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check_eq("done_seen", bus.done, 1'b1);
    last_done = cyc;
    check_eq("err", bus.err, e_err);
    if (r && !e_err) check_eq("rdata", bus.rdata, e_rdata);
    check_eq("mem_op_count", obs_ops.size(), exp_ops.size());
    n = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) begin
      check_eq("mem_op_we", obs_ops[i].we, exp_ops[i].we);
      check_eq("mem_op_addr", obs_ops[i].addr, exp_ops[i].addr);
      if (exp_ops[i].we) check_eq("mem_op_wdata", obs_ops[i].wdata, exp_ops[i].wdata);
      check_eq("mem_req_stable", obs_ops[i].stable, 1'b1);
    end
    if (exp_ops.size() == 0) check_eq("latency_no_mem", last_done - last_acc, 1);
    @(posedge clk); #1;
    check_eq("done_one_cycle", bus.done, 1'b0);
    check_eq("avail_after_resp", bus.avail, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    int t;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    gnt_wait_cfg = -1;
    rv_wait_cfg = -1;
    m_valid = 0; m_dirty = 0; m_addr = '0; m_data = '0;
    resp_mem[16'h10]  = 32'hDEADBEEF;
    model_mem[16'h10] = 32'hDEADBEEF;
    bus.h = '0;
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_avail", bus.avail, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 0);
    rst_l = 1'b1;
    #1;
    check_eq("avail_low_at_release", bus.avail, 1'b0);
    @(posedge clk); #1;
    check_eq("avail_first_edge", bus.avail, 1'b1);

    // Buffered read miss then hit.
    do_req(1, 0, 23'h10, 0, 0, 0, 23'h0, 23'h100);
    if (obs_ops.size() > 0) check_eq("rd_req_at_n1", obs_ops[0].first_cyc - last_acc, 1);
    do_req(1, 0, 23'h10, 0, 0, 0, 23'h0, 23'h100);
    // Write-back write, then a miss that forces a flush.
    do_req(0, 1, 23'h20, 32'h1234, 0, 0, 23'h0, 23'h100);
    do_req(1, 0, 23'h30, 0, 0, 0, 23'h0, 23'h100);
    // Rejects: end bound exclusive, both enables, empty region.
    do_req(1, 0, 23'h100, 0, 0, 0, 23'h0, 23'h100);
    do_req(1, 1, 23'h10, 0, 0, 0, 23'h0, 23'h100);
    do_req(0, 1, 23'h10, 32'h99, 0, 0, 23'h20, 23'h20);
    // Write-through to a clean buffered address, then a buffered read.
    do_req(1, 0, 23'h40, 0, 0, 0, 23'h0, 23'h100);
    do_req(0, 1, 23'h40, 32'h55, 1, 0, 23'h0, 23'h100);
    do_req(1, 0, 23'h40, 0, 0, 0, 23'h0, 23'h100);
    check_eq("wt_then_hit_rdata", bus.rdata, 32'h55);

    // Slow grant and delayed read data.
    gnt_wait_cfg = 5;
    rv_wait_cfg = 3;
    do_req(1, 0, 23'h50, 0, 0, 1, 23'h0, 23'h100);
    if (obs_ops.size() > 0) begin
      check_eq("slow_gnt_req_cycles", obs_ops[0].req_cycles, 6);
      check_eq("slow_gnt_stable", obs_ops[0].stable, 1'b1);
      check_eq("rvalid_to_done", last_done - obs_ops[0].gnt_cyc, 4);
    end

    // Reset while waiting for read data; the dirty word at 0x70 is dropped.
    gnt_wait_cfg = -1;
    rv_wait_cfg = -1;
    do_req(0, 1, 23'h70, 32'hABCD, 0, 0, 23'h0, 23'h100);
    gnt_wait_cfg = 0;
    rv_wait_cfg = 6;
    wait_avail();
    obs_ops.delete();
    bus.h.r_en = 1'b1;  bus.h.w_en = 1'b0;  bus.h.ptr = 23'h60;
    bus.h.read_through = 1'b1;  bus.h.write_through = 1'b0;
    bus.h.region_begin = 23'h0;  bus.h.region_end = 23'h100;
    @(posedge clk); #1;
    bus.h.r_en = 1'b0;
    t = 0;
    while (obs_ops.size() == 0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check_eq("rst_test_granted", obs_ops.size(), 1);
    @(posedge clk); #1;
    rst_l = 1'b0;
    #1;
    check_eq("midrst_avail", bus.avail, 1'b0);
    check_eq("midrst_done", bus.done, 1'b0);
    check_eq("midrst_err", bus.err, 1'b0);
    check_eq("midrst_rdata", bus.rdata, 0);
    check_eq("midrst_mem_req", bus.mem_req, 1'b0);
    check_eq("midrst_mem_we", bus.mem_we, 1'b0);
    check_eq("midrst_mem_addr", bus.mem_addr, 0);
    check_eq("midrst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    check_eq("midrst_avail_release", bus.avail, 1'b0);
    @(posedge clk); #1;
    check_eq("midrst_avail_edge", bus.avail, 1'b1);
    done_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check_eq("late_rvalid_no_done", done_cnt, 0);
    m_valid = 0;
    m_dirty = 0;
    gnt_wait_cfg = -1;
    rv_wait_cfg = -1;

    // Randomized traffic over a small address pool to exercise hits and flushes.
    for (int i = 0; i < 250; i++) begin
      logic                 r, w, wt, rt;
      logic [ADDR_SIZE-1:0] ptr, rb, re;
      logic [DATA_SIZE-1:0] d;
      int                   kind, rsel;
      kind = int'($urandom_range(0, 19));
      r = (kind <= 9);
      w = (kind == 0) || (kind > 9);
      wt = 1'($urandom_range(0, 1));
      rt = ($urandom_range(0, 3) == 0);
      d = $urandom;
      ptr = ($urandom_range(0, 9) == 0) ? 23'($urandom_range(0, 'h200)) : 23'(16 + $urandom_range(0, 15));
      rsel = int'($urandom_range(0, 9));
      if (rsel == 0) begin
        rb = 23'($urandom_range(0, 'h20));
        re = 23'($urandom_range(0, int'(rb)));
      end else if (rsel == 1) begin
        rb = 23'h14;
        re = 23'h1A;
      end else begin
        rb = 23'h0;
        re = 23'h100;
      end
      do_req(r, w, ptr, d, wt, rt, rb, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
